// File: rtl/slot_grid_engine.sv
// Slot-grid game core: N x N grid of LFSR-drawn symbols, re-drawn during a roll,
// then every row, column and diagonal is scored into a saturating running total.
module slot_grid_engine #(
  parameter int          GRID_N      = 3,
  parameter int          SYM_BITS    = 2,
  parameter int          NUM_SYM     = 4,
  parameter int          TICK_CYCLES = 1000000,
  parameter int          ROLL_CYCLES = 20000000,
  parameter int          SCORE_W     = 6,
  parameter int          LINE_POINTS = 5,
  parameter int          WIN_SCORE   = 50,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  hold,
  input  logic                                  ack,
  input  logic                                  cell_we,
  input  logic [$clog2(GRID_N*GRID_N)-1:0]      cell_idx,
  input  logic [SYM_BITS-1:0]                   cell_sym,
  output logic [GRID_N*GRID_N*SYM_BITS-1:0]     grid,
  output logic [SCORE_W-1:0]                    score,
  output logic [$clog2(2*GRID_N+3)-1:0]         lines_hit,
  output logic                                  busy,
  output logic                                  result_valid,
  output logic                                  win,
  output logic                                  lose
);

  localparam int CELLS  = GRID_N * GRID_N;
  localparam int NLINES = 2 * GRID_N + 2;
  localparam int CIDX_W = $clog2(CELLS);
  localparam int LH_W   = $clog2(2 * GRID_N + 3);
  localparam int TICK_W = $clog2(TICK_CYCLES + 1);
  localparam int ROLL_W = $clog2(ROLL_CYCLES + 1);
  localparam int LINE_W = $clog2(NLINES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_CELLS = TICK_W'(CELLS);
  localparam logic [ROLL_W-1:0] ROLL_LAST  = ROLL_W'(ROLL_CYCLES - 1);
  localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(NLINES - 1);
  localparam logic [31:0]       SCORE_MAX  = 32'((1 << SCORE_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_ROLL, S_EVAL, S_SCORE, S_RESULT} state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [ROLL_W-1:0]   roll_cnt_q, roll_cnt_d;
  logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
  logic                hold_q, hold_d;
  logic [SYM_BITS-1:0] cells_q [CELLS];
  logic [SYM_BITS-1:0] cells_d [CELLS];
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [LH_W-1:0]     lines_hit_q, lines_hit_d;
  logic                win_q, win_d, lose_q, lose_d;
  logic                busy_q, busy_d, result_valid_q, result_valid_d;

  logic [NLINES-1:0]   hit_vec;
  logic                line_hit;
  logic [SYM_BITS-1:0] redraw_sym;
  logic [31:0]         sum_full;
  logic [SCORE_W-1:0]  score_sat;

  // Each line's cell indices are fixed at elaboration; EVAL just selects one hit bit per cycle.
  genvar gi, gk;
  generate
    for (gi = 0; gi < NLINES; gi++) begin : g_line
      logic [GRID_N-1:0] eq;
      for (gk = 0; gk < GRID_N; gk++) begin : g_cell
        localparam int IDX  = (gi < GRID_N)     ? gi * GRID_N + gk :
                              (gi < 2 * GRID_N) ? gk * GRID_N + (gi - GRID_N) :
                              (gi == 2 * GRID_N) ? gk * GRID_N + gk :
                                                   gk * GRID_N + (GRID_N - 1 - gk);
        localparam int IDX0 = (gi < GRID_N)     ? gi * GRID_N :
                              (gi < 2 * GRID_N) ? (gi - GRID_N) :
                              (gi == 2 * GRID_N) ? 0 : (GRID_N - 1);
        assign eq[gk] = (cells_q[IDX] == cells_q[IDX0]);
      end
      assign hit_vec[gi] = &eq;
    end
    for (gi = 0; gi < CELLS; gi++) begin : g_grid
      assign grid[gi*SYM_BITS +: SYM_BITS] = cells_q[gi];
    end
  endgenerate

  assign line_hit   = |(hit_vec & (NLINES'(1) << line_cnt_q));
  assign redraw_sym = SYM_BITS'(lfsr_q[7:0] % 8'(NUM_SYM));
  assign lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign sum_full   = 32'(score_q) + 32'(lines_hit_q) * 32'(LINE_POINTS);
  assign score_sat  = (sum_full > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : sum_full[SCORE_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ROLL;
      S_ROLL:   if (roll_cnt_q == ROLL_LAST) state_d = S_EVAL;
      S_EVAL:   if (line_cnt_q == LINE_LAST) state_d = S_SCORE;
      S_SCORE:  state_d = S_RESULT;
      S_RESULT: if (ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d         = (state_d == S_ROLL) || (state_d == S_EVAL) || (state_d == S_SCORE);
    result_valid_d = (state_d == S_RESULT);
  end

  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    roll_cnt_d  = roll_cnt_q;
    line_cnt_d  = line_cnt_q;
    hold_d      = hold_q;
    score_d     = score_q;
    lines_hit_d = lines_hit_q;
    win_d       = win_q;
    lose_d      = lose_q;
    for (int i = 0; i < CELLS; i++) cells_d[i] = cells_q[i];
    case (state_q)
      S_IDLE: begin
        if (cell_we && (int'(cell_idx) < CELLS)) cells_d[cell_idx] = cell_sym;
        if (start) begin
          roll_cnt_d = '0;
          tick_cnt_d = '0;
          hold_d     = hold;
        end
      end
      S_ROLL: begin
        // A re-draw occupies the first CELLS cycles of every tick period.
        if (!hold_q && (tick_cnt_q < TICK_CELLS)) cells_d[tick_cnt_q[CIDX_W-1:0]] = redraw_sym;
        roll_cnt_d = roll_cnt_q + ROLL_W'(1);
        tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
        if (roll_cnt_q == ROLL_LAST) begin
          line_cnt_d  = '0;
          lines_hit_d = '0;
        end
      end
      S_EVAL: begin
        line_cnt_d  = line_cnt_q + LINE_W'(1);
        lines_hit_d = lines_hit_q + LH_W'(line_hit);
      end
      S_SCORE: begin
        if (lines_hit_q == '0) begin
          lose_d = 1'b1;
        end else begin
          score_d = score_sat;
          win_d   = (32'(score_sat) >= 32'(WIN_SCORE));
        end
      end
      S_RESULT: begin
        if (ack) begin
          if (win_q || lose_q) score_d = '0;
          win_d  = 1'b0;
          lose_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q         <= SEED;
      tick_cnt_q     <= '0;
      roll_cnt_q     <= '0;
      line_cnt_q     <= '0;
      hold_q         <= 1'b0;
      score_q        <= '0;
      lines_hit_q    <= '0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      for (int i = 0; i < CELLS; i++) cells_q[i] <= '0;
    end else begin
      lfsr_q         <= lfsr_d;
      tick_cnt_q     <= tick_cnt_d;
      roll_cnt_q     <= roll_cnt_d;
      line_cnt_q     <= line_cnt_d;
      hold_q         <= hold_d;
      score_q        <= score_d;
      lines_hit_q    <= lines_hit_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      for (int i = 0; i < CELLS; i++) cells_q[i] <= cells_d[i];
    end
  end

  assign score        = score_q;
  assign lines_hit    = lines_hit_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign win          = win_q;
  assign lose         = lose_q;

endmodule
